// File: rtl/sub4_core.sv
// Registered ripple-carry subtractor: {carry_out, sub_out} = a + ~b + cin, where carry_out = 1 means no borrow.
// Latency: 1 cycle from an accepted in_valid to out_valid and result; there are no combinational paths from inputs to outputs.
// Backpressure: none. Every in_valid cycle is accepted, and back-to-back inputs give back-to-back results in order.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; has priority over in_valid
//   in_valid   a/b (and borrow_in) are valid this cycle
//   a, b       WIDTH-bit unsigned minuend / subtrahend
//   borrow_in  borrow into the LSB (only when SUB4_BORROW_IN_EN is defined)
//   sub_out    registered difference, modulo 2^WIDTH
//   carry_out  registered carry out of the MSB (1 = a >= b [+ borrow_in])
//   out_valid  result registers were loaded by the previous cycle's input
//
// Build option: define SUB4_BORROW_IN_EN to add the borrow_in port, with cin = ~borrow_in.
// Without it, cin is tied to 1.
module sub4_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUB4_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic [WIDTH-1:0] sub_out,
    output logic             carry_out,
    output logic             out_valid
);

    logic             w_cin;
    logic [WIDTH-1:0] w_b_n;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;

    logic [WIDTH-1:0] r_sub;
    logic             r_carry;
    logic             r_valid;

    // A borrow into the LSB is the same as dropping the "+1" of the two's complement.
`ifdef SUB4_BORROW_IN_EN
    assign w_cin = ~borrow_in;
`else
    assign w_cin = 1'b1;
`endif

    assign w_b_n = ~b;

    // Bitwise ripple chain of full adders. It is kept in one process so that
    // the carry vector is written and read in a single block.
    always_comb begin
        w_sum  = '0;
        w_c    = '0;
        w_c[0] = w_cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]  = a[i] ^ w_b_n[i] ^ w_c[i];
            w_c[i+1]  = (a[i] & w_b_n[i]) | (a[i] & w_c[i]) | (w_b_n[i] & w_c[i]);
        end
    end

    // The result registers hold when in_valid is low, so the outputs keep the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sub   <= w_sum;
                r_carry <= w_c[WIDTH];
            end
        end
    end

    assign sub_out   = r_sub;
    assign carry_out = r_carry;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_sub4_core.sv
// Scoreboard bench for sub4_core (WIDTH = 4).
// The driver changes inputs on the falling edge and queues the outputs expected after the next rising edge.
// The monitor samples 2 time units after each rising edge and compares the outputs with the queue.
module tb_sub4_core;

    localparam int W = 4;
`ifdef SUB4_BORROW_IN_EN
    localparam int NBIN = 2;
`else
    localparam int NBIN = 1;
`endif

    typedef struct packed {
        logic         vld;
        logic [W-1:0] sub;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic [W-1:0] sub_out;
    logic         carry_out;
    logic         out_valid;

    exp_t q[$];
    exp_t last_exp = '0;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    sub4_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef SUB4_BORROW_IN_EN
        .borrow_in (bin),
`endif
        .sub_out   (sub_out),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Apply one cycle of input and queue what the outputs must show after the next rising edge.
    // For cycles that are not loaded (idle or reset), the expected value is the held value or zero.
    task automatic drive(input logic r, input logic v, input int av, input int bv,
                         input logic bi, input int es, input logic ec);
        exp_t e;
        rst      = r;
        in_valid = v;
        a        = W'(av);
        b        = W'(bv);
        bin      = bi;
        if (r) begin
            e        = '0;
            last_exp = '0;
        end else if (v) begin
            e.vld    = 1'b1;
            e.sub    = W'(es);
            e.c      = ec;
            last_exp = e;
        end else begin
            e     = last_exp;
            e.vld = 1'b0;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    // Reference model used only by the sweep: plain integer a - b - borrow.
    task automatic drive_ref(input int av, input int bv, input logic bi);
        int d;
        logic [W-1:0] ds;
        d  = av - bv - int'(bi);
        ds = W'(d);
        drive(1'b0, 1'b1, av, bv, bi, int'(ds), (d >= 0));
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out_valid !== e.vld) begin
                    errors++;
                    $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e.vld, $time);
                end
                checks++;
                if (sub_out !== e.sub) begin
                    errors++;
                    $display("FAIL sub_out: got %0d expected %0d at %0t", sub_out, e.sub, $time);
                end
                checks++;
                if (carry_out !== e.c) begin
                    errors++;
                    $display("FAIL carry_out: got %b expected %b at %0t", carry_out, e.c, $time);
                end
            end else if (!stim_done) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end
        end
    end

    // Driver
    initial begin
        // Hold reset for two cycles while a valid input is present, then release with one idle cycle.
        drive(1'b1, 1'b1, 7, 1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, 7, 1, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 7, 1, 1'b0, 0, 1'b0);

        // Results that are not negative, given back to back.
        drive(1'b0, 1'b1, 4, 0, 1'b0, 4, 1'b1);
        drive(1'b0, 1'b1, 4, 1, 1'b0, 3, 1'b1);
        drive(1'b0, 1'b1, 4, 2, 1'b0, 2, 1'b1);
        drive(1'b0, 1'b1, 4, 3, 1'b0, 1, 1'b1);
        drive(1'b0, 1'b1, 4, 4, 1'b0, 0, 1'b1);

        // Results that borrow and wrap.
        drive(1'b0, 1'b1, 2, 4, 1'b0, 14, 1'b0);
        drive(1'b0, 1'b1, 2, 5, 1'b0, 13, 1'b0);
        drive(1'b0, 1'b1, 0, 15, 1'b0, 1, 1'b0);
        drive(1'b0, 1'b1, 0, 1, 1'b0, 15, 1'b0);
        drive(1'b0, 1'b1, 15, 0, 1'b0, 15, 1'b1);

        // Equal operands and zero operands.
        drive(1'b0, 1'b1, 3, 3, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b1);

        // Hold: the result stays 3 while other operands sit on the bus with in_valid low.
        drive(1'b0, 1'b1, 4, 1, 1'b0, 3, 1'b1);
        drive(1'b0, 1'b0, 9, 2, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 9, 2, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 9, 2, 1'b0, 0, 1'b0);

        // Reset in the middle of a stream discards the input that arrives with it.
        drive(1'b0, 1'b1, 6, 1, 1'b0, 5, 1'b1);
        drive(1'b1, 1'b1, 9, 3, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 9, 3, 1'b0, 0, 1'b0);

`ifdef SUB4_BORROW_IN_EN
        drive(1'b0, 1'b1, 4, 4, 1'b1, 15, 1'b0);
        drive(1'b0, 1'b1, 4, 3, 1'b1, 0, 1'b1);
`endif

        // Full operand sweep against the integer reference (with borrow_in, when it exists).
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < NBIN; z++)
                    drive_ref(x, y, z[0]);

        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        stim_done = 1'b1;
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
